// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through channels 0..3, samples y at the end of each dwell, emits a 4-bit word.
// Latency: data_valid rises 4*SETTLE_CYCLES edges after the accepted start edge; back-to-back in continuous mode.
// No backpressure: start is dropped (not queued) while busy; data_valid is a one-cycle pulse with no ready.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CW            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Dwell counter value on the edge where the current channel is sampled.
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    state_t        state, state_n;
    logic [1:0]    channel, channel_n;
    logic [CW-1:0] count, count_n;
    logic [2:0]    capture, capture_n;
    logic [3:0]    data_n;
    logic          valid_n;

    // Selects come straight from the channel register so they only move on channel transitions.
    assign s0   = channel[0];
    assign s1   = channel[1];
    assign busy = (state == SCAN);

    // Next-state logic: dwell counting, per-channel capture, completion and continuous restart.
    always_comb begin
        state_n   = state;
        channel_n = channel;
        count_n   = count;
        capture_n = capture;
        data_n    = data_out;
        valid_n   = 1'b0;
        case (state)
            IDLE: begin
                channel_n = 2'd0;
                count_n   = '0;
                if (start) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (count == LAST) begin
                    count_n = '0;
                    if (channel != 2'd3) begin
                        for (int n = 0; n < 3; n++) begin
                            if (channel == 2'(n)) begin
                                capture_n[n] = y_in;
                            end
                        end
                        channel_n = channel + 2'd1;
                    end else begin
                        // Channel 3 is sampled directly into the result; start is ignored here,
                        // only cont decides whether another scan follows without a gap.
                        data_n    = {y_in, capture};
                        valid_n   = 1'b1;
                        channel_n = 2'd0;
                        if (!cont) begin
                            state_n = IDLE;
                        end
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                channel_n = 2'd0;
                count_n   = '0;
            end
        endcase
    end

    // State register; reset abandons any scan in flight and clears the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            channel    <= 2'd0;
            count      <= '0;
            capture    <= 3'd0;
            data_out   <= 4'd0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_n;
            channel    <= channel_n;
            count      <= count_n;
            capture    <= capture_n;
            data_out   <= data_n;
            data_valid <= valid_n;
        end
    end

endmodule
